axi_lite_adder_master: RTL and testbench

AXI_LITE_ADDER_MASTER -- requirements
Module: axi_lite_adder_master

---
 rtl/axi_lite_adder_master.sv | 192 +++++++++++++++++++
 tb/tb_axi_lite_adder_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_adder_master.sv
// rtl/axi_lite_adder_master.sv - AXI4-Lite master: writes op_a/op_b to an adder slave, reads back the sum
// Optional watchdog enabled by defining ADDER_MASTER_TIMEOUT_EN.
module axi_lite_adder_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] OPA_ADDR = 'h0,
  parameter logic [ADDR_WIDTH-1:0] OPB_ADDR = 'h4,
  parameter logic [ADDR_WIDTH-1:0] RES_ADDR = 'h8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      M_AXI_ACLK,
  input  logic                      M_AXI_ARESETN,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     op_a,
  input  logic [DATA_WIDTH-1:0]     op_b,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_WIDTH-1:0]     result,
  output logic                      error,
  output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] opb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  second_write;
  logic                  aw_done;
  logic                  w_done;
  logic                  aw_fin;
  logic                  w_fin;

  assign M_AXI_WSTRB = '1;

  // A channel counts as finished if it completed earlier or is completing on this edge.
  assign aw_fin = aw_done | (M_AXI_AWVALID & M_AXI_AWREADY);
  assign w_fin  = w_done  | (M_AXI_WVALID  & M_AXI_WREADY);

`ifdef ADDER_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CYCLE = CW'(TIMEOUT_CYCLES - 1);

  state_t          prev_state;
  logic [CW-1:0]   wait_cnt;
  logic [CW-1:0]   cnt_cur;
  logic            waiting;
  logic            timeout_hit;

  // wait_cnt holds the cycles already spent in the current state; a state change restarts it.
  assign waiting     = state inside {WRITE, WRESP, RADDR, RDATA};
  assign cnt_cur     = (state == prev_state) ? wait_cnt : '0;
  assign timeout_hit = waiting && (cnt_cur == LAST_CYCLE);

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      prev_state <= IDLE;
      wait_cnt   <= '0;
    end else begin
      prev_state <= state;
      wait_cnt   <= waiting ? cnt_cur + CW'(1) : '0;
    end
  end
`else
  if (TIMEOUT_CYCLES > 0) begin : g_no_watchdog
  end
`endif

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      result        <= '0;
      opb_q         <= '0;
      rdata_q       <= '0;
      second_write  <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
`ifdef ADDER_MASTER_TIMEOUT_EN
      if (timeout_hit) begin
        M_AXI_AWVALID <= 1'b0;
        M_AXI_WVALID  <= 1'b0;
        M_AXI_BREADY  <= 1'b0;
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY  <= 1'b0;
        aw_done       <= 1'b0;
        w_done        <= 1'b0;
        error         <= 1'b1;
        rdata_q       <= result;  // keeps result unchanged when DONE publishes rdata_q
        state         <= DONE;
      end else
`endif
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            opb_q         <= op_b;
            error         <= 1'b0;
            busy          <= 1'b1;
            second_write  <= 1'b0;
            M_AXI_AWADDR  <= OPA_ADDR;
            M_AXI_WDATA   <= op_a;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            state         <= WRITE;
          end
        end
        WRITE: begin
          if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
          if (aw_fin && w_fin) begin
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            M_AXI_BREADY <= 1'b1;
            state        <= WRESP;
          end else begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
          end
        end
        WRESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            if (M_AXI_BRESP != 2'b00) error <= 1'b1;
            if (!second_write) begin
              second_write  <= 1'b1;
              M_AXI_AWADDR  <= OPB_ADDR;
              M_AXI_WDATA   <= opb_q;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= WRITE;
            end else begin
              M_AXI_ARADDR  <= RES_ADDR;
              M_AXI_ARVALID <= 1'b1;
              state         <= RADDR;
            end
          end
        end
        RADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RDATA;
          end
        end
        RDATA: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            rdata_q      <= M_AXI_RDATA;
            if (M_AXI_RRESP != 2'b00) error <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          result <= rdata_q;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_adder_master.sv
// tb/tb_axi_lite_adder_master.sv - randomized bench with an adder slave and sum/error reference model
module tb_axi_lite_adder_master;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam logic [AW-1:0] OPA = 4'h0;
  localparam logic [AW-1:0] OPB = 4'h4;
  localparam logic [AW-1:0] RES = 4'h8;
  localparam logic [AW-1:0] NO_BAD = 4'hF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start;
  logic [DW-1:0] op_a, op_b;
  logic          busy, done, error;
  logic [DW-1:0] result;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  axi_lite_adder_master dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .error(error),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // Adder slave: ready after a programmable number of waiting cycles, registered responses.
  int            aw_dly, w_dly, ar_dly;
  logic [AW-1:0] bad_b_addr;
  logic          bad_r;
  int            aw_cnt, w_cnt, ar_cnt, n_wr, n_rd;
  logic [DW-1:0] slv_a, slv_b, w_data_q;
  logic [AW-1:0] aw_addr_q, rd_addr_last;
  logic          have_aw, have_w;
  logic          aw_hs, w_hs, wr_commit;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  assign awready   = (aw_cnt >= aw_dly);
  assign wready    = (w_cnt >= w_dly);
  assign arready   = (ar_cnt >= ar_dly);
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign wr_commit = (aw_hs || have_aw) && (w_hs || have_w);
  assign wr_addr   = aw_hs ? awaddr : aw_addr_q;
  assign wr_data   = w_hs ? wdata : w_data_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      have_aw <= 1'b0; have_w <= 1'b0;
      aw_addr_q <= '0; w_data_q <= '0;
      slv_a <= '0; slv_b <= '0;
      bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
      rd_addr_last <= '0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (aw_hs) begin have_aw <= 1'b1; aw_addr_q <= awaddr; end
      if (w_hs) begin have_w <= 1'b1; w_data_q <= wdata; end
      if (wr_commit) begin
        if (wr_addr == OPA) slv_a <= wr_data;
        else if (wr_addr == OPB) slv_b <= wr_data;
        bvalid  <= 1'b1;
        bresp   <= (wr_addr == bad_b_addr) ? 2'b10 : 2'b00;
        have_aw <= 1'b0;
        have_w  <= 1'b0;
        n_wr    <= n_wr + 1;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
      if (arvalid && arready) begin
        rvalid       <= 1'b1;
        rdata        <= (araddr == RES) ? slv_a + slv_b : '0;
        rresp        <= bad_r ? 2'b10 : 2'b00;
        rd_addr_last <= araddr;
        n_rd         <= n_rd + 1;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  int done_cnt, arv_cycles;
  initial begin n_wr = 0; n_rd = 0; done_cnt = 0; arv_cycles = 0; end
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (arvalid) arv_cycles <= arv_cycles + 1;
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] last_exp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic run_seq(input logic [DW-1:0] a, input logic [DW-1:0] b, input int awd, input int wd,
                         input int ard, input logic [AW-1:0] badb, input logic badr,
                         input bit extra_start, input bit chk_lat, input bit chk_hold);
    logic [DW-1:0] exp_res;
    logic          exp_err;
    int            d0, wr0, rd0, cyc;
    bit            seen;
    exp_res = a + b;
    exp_err = (badb == OPA) || (badb == OPB) || badr;
    aw_dly = awd; w_dly = wd; ar_dly = ard; bad_b_addr = badb; bad_r = badr;
    d0 = done_cnt; wr0 = n_wr; rd0 = n_rd;
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    cyc = 0; seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        check("busy_set", busy, 1);
        op_a = $urandom; op_b = $urandom;
      end
      if (extra_start && cyc == 3) start = 1'b1;
      if (extra_start && cyc == 4) start = 1'b0;
      if (chk_hold && (cyc == 2 || cyc == 3)) begin
        check("wvalid_dropped", wvalid, 0);
        check("awvalid_held", awvalid, 1);
        check("awaddr_held", awaddr, OPA);
      end
      if (done) seen = 1;
    end
    check("done_seen", seen, 1);
    if (chk_lat) check("latency", cyc - 1, 7);
    check("result", result, exp_res);
    check("error", error, exp_err);
    check("write_count", n_wr - wr0, 2);
    check("read_count", n_rd - rd0, 1);
    check("slave_a", slv_a, a);
    check("slave_b", slv_b, b);
    check("read_addr", rd_addr_last, RES);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_clear", busy, 0);
    check("result_hold", result, exp_res);
    repeat (6) @(negedge clk);
    check("done_count", done_cnt - d0, 1);
    last_exp = exp_res;
  endtask

  initial begin
    int cyc;
    start = 1'b0; op_a = '0; op_b = '0;
    aw_dly = 0; w_dly = 0; ar_dly = 0; bad_b_addr = NO_BAD; bad_r = 1'b0;
    last_exp = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_result", result, 0);
    check("rst_valids", {awvalid, wvalid, arvalid}, 0);
    check("rst_readies", {bready, rready}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_seq(32'd10, 32'd32, 0, 0, 0, NO_BAD, 1'b0, 0, 1, 0);
    run_seq(32'hFFFF_FFFF, 32'd1, 0, 0, 0, NO_BAD, 1'b0, 0, 1, 0);
    run_seq(32'd100, 32'd23, 3, 0, 0, NO_BAD, 1'b0, 0, 0, 1);
    run_seq(32'd7, 32'd8, 0, 0, 0, OPB, 1'b0, 0, 0, 0);
    run_seq(32'd1000, 32'd2000, 0, 0, 0, NO_BAD, 1'b0, 1, 1, 0);

    // Reset while the master waits for a write response.
    aw_dly = 0; w_dly = 0; ar_dly = 0; bad_b_addr = NO_BAD; bad_r = 1'b0;
    @(negedge clk);
    op_a = 32'd10; op_b = 32'd32; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!bready && cyc < 20) begin @(negedge clk); cyc++; end
    check("reach_wresp", bready, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_error_done", {error, done}, 0);
    check("abort_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    check("abort_addr_data", {awaddr, araddr, wdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_seq(32'd10, 32'd32, 0, 0, 0, NO_BAD, 1'b0, 0, 1, 0);

`ifdef ADDER_MASTER_TIMEOUT_EN
    begin
      int a0;
      bit seen;
      aw_dly = 0; w_dly = 0; ar_dly = 100000; bad_b_addr = NO_BAD; bad_r = 1'b0;
      a0 = arv_cycles;
      @(negedge clk);
      op_a = 32'd5; op_b = 32'd6; start = 1'b1;
      cyc = 0; seen = 0;
      while (!seen && cyc < 400) begin
        @(negedge clk);
        cyc++;
        if (cyc == 1) start = 1'b0;
        if (done) seen = 1;
      end
      check("to_done", seen, 1);
      check("to_error", error, 1);
      check("to_result", result, last_exp);
      check("to_arvalid", arvalid, 0);
      check("to_ar_cycles", arv_cycles - a0, 255);
      ar_dly = 0;
      repeat (3) @(negedge clk);
    end
`endif

    for (int i = 0; i < 12; i++) begin
      int pick;
      logic [AW-1:0] badb;
      pick = $urandom_range(0, 3);
      badb = (pick == 0) ? OPA : (pick == 1) ? OPB : NO_BAD;
      run_seq($urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), badb, ($urandom_range(0, 3) == 0), 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
